// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared Keccak state geometry and squeeze FSM type
package keccak_pkg;

    localparam int STATE_W  = 1600;
    localparam int LANE_W   = 64;
    localparam int LANE_CNT = 25;

    typedef enum logic {
        SQ_IDLE,
        SQ_SEND
    } sq_state_t;

endpackage

// File: rtl/keccak_squeeze_out.sv
// rtl/keccak_squeeze_out.sv - captures the final Keccak state and streams the truncated digest
module keccak_squeeze_out
    import keccak_pkg::*;
#(
    parameter int WORD_W   = 64,
    parameter int OUT_BITS = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STATE_W-1:0] state_in,
    input  logic               state_valid,
    output logic               state_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy
);

    localparam int NUM_WORDS = OUT_BITS / WORD_W;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    // Reject digest geometries that cannot be cut into whole words of the state.
    if (((OUT_BITS % WORD_W) != 0) || (OUT_BITS > STATE_W)) begin : g_param_check
        $fatal(1, "keccak_squeeze_out: OUT_BITS must be a multiple of WORD_W and at most 1600");
    end

    sq_state_t             state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [OUT_BITS-1:0]   dig_q, dig_d;
    logic                  send;

    assign send = (state_q == SQ_SEND);

    // State, word index and digest buffer registers; reset discards any partial digest.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SQ_IDLE;
            idx_q   <= '0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dig_q   <= dig_d;
        end
    end

    // Next state: capture the truncated state in IDLE, advance the word index on each transfer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dig_d   = dig_q;
        unique case (state_q)
            SQ_IDLE: begin
                if (state_valid) begin
                    dig_d   = state_in[OUT_BITS-1:0];
                    idx_d   = '0;
                    state_d = SQ_SEND;
                end
            end
            SQ_SEND: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = SQ_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = SQ_IDLE;
        endcase
    end

    // Outputs depend only on registered state so no input reaches an output combinationally.
    always_comb begin
        out_valid   = send;
        busy        = send;
        state_ready = !send;
        out_last    = send && (idx_q == LAST_IDX);
        out_data    = send ? dig_q[WORD_W*idx_q +: WORD_W] : '0;
    end

endmodule

// File: tb/tb_keccak_squeeze_out.sv
// tb/tb_keccak_squeeze_out.sv - scoreboard bench for keccak_squeeze_out in two geometries
module tb_keccak_squeeze_out;

    typedef logic [63:0] lanes_t [25];

    logic          clk = 1'b0;
    logic          rst;
    logic [1599:0] state_in;
    int            cyc = 0;

    logic        sv_a, rdy_a, a_sready, a_valid, a_last, a_busy;
    logic [63:0] a_data;
    logic        sv_b, rdy_b, b_sready, b_valid, b_last, b_busy;
    logic [31:0] b_data;

    logic [63:0] exp_da[$];
    logic        exp_la[$];
    logic [31:0] exp_db[$];
    logic        exp_lb[$];
    int          xa_cyc[$];
    int          xb_cyc[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    keccak_squeeze_out #(.WORD_W(64), .OUT_BITS(256)) dut_a (
        .clk(clk), .rst(rst), .state_in(state_in), .state_valid(sv_a),
        .state_ready(a_sready), .out_data(a_data), .out_valid(a_valid),
        .out_ready(rdy_a), .out_last(a_last), .busy(a_busy)
    );

    keccak_squeeze_out #(.WORD_W(32), .OUT_BITS(224)) dut_b (
        .clk(clk), .rst(rst), .state_in(state_in), .state_valid(sv_b),
        .state_ready(b_sready), .out_data(b_data), .out_valid(b_valid),
        .out_ready(rdy_b), .out_last(b_last), .busy(b_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Digest word k is the w bits starting at bit k*w of the little-endian lane sequence.
    function automatic logic [63:0] ref_word(input lanes_t l, input int w, input int k);
        int          p;
        logic [63:0] v;
        p = k * w;
        v = l[p / 64] >> (p % 64);
        if (w < 64) v = v & ((64'd1 << w) - 64'd1);
        return v;
    endfunction

    function automatic logic [1599:0] pack(input lanes_t l);
        logic [1599:0] r;
        for (int i = 0; i < 25; i++) r[64*i +: 64] = l[i];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input lanes_t l);
        for (int k = 0; k < 4; k++) begin
            exp_da.push_back(ref_word(l, 64, k));
            exp_la.push_back(k == 3);
        end
    endtask

    task automatic push_b(input lanes_t l);
        logic [63:0] w;
        for (int k = 0; k < 7; k++) begin
            w = ref_word(l, 32, k);
            exp_db.push_back(w[31:0]);
            exp_lb.push_back(k == 6);
        end
    endtask

    // Called just after a rising edge; the state is sampled on the following edge.
    task automatic drive_a(input lanes_t l, input bit cap, output int c);
        state_in = pack(l);
        sv_a = 1'b1;
        if (cap) push_a(l);
        c = cyc;
        step();
        sv_a = 1'b0;
    endtask

    task automatic drive_b(input lanes_t l, input bit cap, output int c);
        state_in = pack(l);
        sv_b = 1'b1;
        if (cap) push_b(l);
        c = cyc;
        step();
        sv_b = 1'b0;
    endtask

    task automatic wait_idle_a();
        int t;
        rdy_a = 1'b1;
        for (t = 0; t < 100; t++) begin
            if (exp_da.size() == 0 && a_sready) break;
            step();
        end
        if (t == 100) begin
            errors++;
            checks++;
            $display("FAIL a_wait_idle: got timeout expected idle");
        end
        @(negedge clk);
        chk("a_idle_valid", a_valid, 0);
        chk("a_idle_sready", a_sready, 1);
    endtask

    task automatic wait_idle_b();
        int t;
        rdy_b = 1'b1;
        for (t = 0; t < 100; t++) begin
            if (exp_db.size() == 0 && b_sready) break;
            step();
        end
        if (t == 100) begin
            errors++;
            checks++;
            $display("FAIL b_wait_idle: got timeout expected idle");
        end
        @(negedge clk);
        chk("b_idle_valid", b_valid, 0);
        chk("b_idle_sready", b_sready, 1);
    endtask

    // Monitor for the 64/256 instance: pops the scoreboard on every transfer.
    initial begin
        logic [63:0] prev_d;
        logic        prev_l;
        bit          stall;
        logic [63:0] ed;
        logic        el;
        stall = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 0;
            end else if (a_valid) begin
                chk("a_sready_in_send", a_sready, 0);
                chk("a_busy_in_send", a_busy, 1);
                if (stall) begin
                    chk("a_stall_data", a_data, prev_d);
                    chk("a_stall_last", a_last, prev_l);
                end
                if (rdy_a) begin
                    checks++;
                    if (exp_da.size() == 0) begin
                        errors++;
                        $display("FAIL a_unexpected_word: got %h expected no word", a_data);
                    end else begin
                        ed = exp_da.pop_front();
                        el = exp_la.pop_front();
                        if (a_data !== ed || a_last !== el) begin
                            errors++;
                            $display("FAIL a_word: got %h last=%b expected %h last=%b", a_data, a_last, ed, el);
                        end
                        xa_cyc.push_back(cyc + 1);
                    end
                end
                stall  = !rdy_a;
                prev_d = a_data;
                prev_l = a_last;
            end else begin
                stall = 0;
                chk("a_idle_busy", a_busy, 0);
            end
        end
    end

    // Monitor for the 32/224 instance.
    initial begin
        logic [31:0] prev_d;
        logic        prev_l;
        bit          stall;
        logic [31:0] ed;
        logic        el;
        stall = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 0;
            end else if (b_valid) begin
                chk("b_sready_in_send", b_sready, 0);
                chk("b_busy_in_send", b_busy, 1);
                if (stall) begin
                    chk("b_stall_data", b_data, prev_d);
                    chk("b_stall_last", b_last, prev_l);
                end
                if (rdy_b) begin
                    checks++;
                    if (exp_db.size() == 0) begin
                        errors++;
                        $display("FAIL b_unexpected_word: got %h expected no word", b_data);
                    end else begin
                        ed = exp_db.pop_front();
                        el = exp_lb.pop_front();
                        if (b_data !== ed || b_last !== el) begin
                            errors++;
                            $display("FAIL b_word: got %h last=%b expected %h last=%b", b_data, b_last, ed, el);
                        end
                        xb_cyc.push_back(cyc + 1);
                    end
                end
                stall  = !rdy_b;
                prev_d = b_data;
                prev_l = b_last;
            end else begin
                stall = 0;
                chk("b_idle_busy", b_busy, 0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        lanes_t lb, l2, lr, lv;
        int     c, c1, c2, n0;
        bit     pat[7];

        rst = 1'b1; sv_a = 1'b0; sv_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0; state_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_a_valid", a_valid, 0);
        chk("rst_a_last", a_last, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_a_sready", a_sready, 1);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_b_data", {32'd0, b_data}, 0);
        chk("rst_b_sready", b_sready, 1);

        for (int i = 0; i < 25; i++) lb[i] = (i < 4) ? 64'(i + 1) : 64'hFFFF_FFFF_FFFF_FFFF;

        // Basic digest with the sink always ready.
        rdy_a = 1'b1;
        step();
        n0 = xa_cyc.size();
        drive_a(lb, 1, c);
        @(negedge clk);
        chk("basic_valid_after_capture", a_valid, 1);
        wait_idle_a();
        chk("basic_first_xfer_cycle", xa_cyc[n0], c + 2);
        chk("basic_last_xfer_cycle", xa_cyc[n0+3], c + 5);

        // Backpressure pattern 1,0,0,1,0,1,1.
        pat = '{1, 0, 0, 1, 0, 1, 1};
        rdy_a = 1'b0;
        step();
        n0 = xa_cyc.size();
        drive_a(lb, 1, c);
        for (int i = 0; i < 7; i++) begin
            rdy_a = pat[i];
            step();
        end
        chk("bp_transfer_count", xa_cyc.size() - n0, 4);
        wait_idle_a();

        // New state offered during SEND must be ignored.
        l2 = lb;
        l2[0] = 64'hDEAD;
        rdy_a = 1'b0;
        step();
        drive_a(lb, 1, c);
        state_in = pack(l2);
        sv_a = 1'b1;
        step();
        step();
        sv_a = 1'b0;
        wait_idle_a();
        repeat (3) step();
        chk("ignored_no_capture", a_valid, 0);

        // Reset after the second word has been transferred.
        rdy_a = 1'b1;
        step();
        drive_a(lb, 1, c);
        step();
        step();
        rst = 1'b1;
        exp_da.delete();
        exp_la.delete();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", a_valid, 0);
        chk("midrst_busy", a_busy, 0);
        chk("midrst_sready", a_sready, 1);
        chk("midrst_data", a_data, 0);
        step();
        n0 = xa_cyc.size();
        drive_a(lb, 1, c);
        wait_idle_a();
        chk("midrst_restart_cycle", xa_cyc[n0], c + 2);

        // Back-to-back digests: second capture in the cycle after the last transfer.
        for (int i = 0; i < 25; i++) lr[i] = {$urandom, $urandom};
        rdy_a = 1'b1;
        step();
        n0 = xa_cyc.size();
        drive_a(lb, 1, c1);
        repeat (4) step();
        drive_a(lr, 1, c2);
        wait_idle_a();
        chk("b2b_capture_cycle", c2, xa_cyc[n0+3]);
        chk("b2b_gap", xa_cyc[n0+4], xa_cyc[n0+3] + 2);

        // Random states with random sink readiness.
        for (int d = 0; d < 6; d++) begin
            for (int i = 0; i < 25; i++) lr[i] = {$urandom, $urandom};
            wait_idle_a();
            step();
            rdy_a = 1'($urandom_range(0, 1));
            drive_a(lr, 1, c);
            for (int t = 0; t < 100 && exp_da.size() != 0; t++) begin
                rdy_a = ($urandom_range(0, 3) != 0);
                step();
            end
        end
        wait_idle_a();

        // 32-bit words, 224-bit digest.
        for (int i = 0; i < 25; i++) lv[i] = 64'hFFFF_FFFF_FFFF_FFFF;
        lv[0] = 64'hBBBB_BBBB_AAAA_AAAA;
        lv[1] = 64'hDDDD_DDDD_CCCC_CCCC;
        lv[2] = 64'hFFFF_FFFF_EEEE_EEEE;
        lv[3] = 64'h9999_9999_8888_8888;
        rdy_b = 1'b1;
        step();
        n0 = xb_cyc.size();
        drive_b(lv, 1, c);
        wait_idle_b();
        chk("v32_first_xfer_cycle", xb_cyc[n0], c + 2);
        chk("v32_last_xfer_cycle", xb_cyc[n0+6], c + 8);

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 25; i++) lr[i] = {$urandom, $urandom};
            wait_idle_b();
            step();
            drive_b(lr, 1, c);
            for (int t = 0; t < 100 && exp_db.size() != 0; t++) begin
                rdy_b = ($urandom_range(0, 2) != 0);
                step();
            end
        end
        wait_idle_b();

        chk("a_scoreboard_empty", exp_da.size(), 0);
        chk("b_scoreboard_empty", exp_db.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keccak_squeeze_out.md
Name: keccak_squeeze_out

Overview:
- Output (squeeze) end of the Keccak datapath; sits downstream of the 1600-bit permutation state register.
- Captures the final state when the permutation core flags completion.
- Streams the first OUT_BITS of that state as WORD_W-bit words over a valid/ready interface, then returns to idle for the next digest.
- Only the truncated digest is buffered internally, not the full 1600 bits.

Parameters:
- WORD_W, 64, output word width in bits; must divide OUT_BITS.
- OUT_BITS, 256, digest length in bits; must be a multiple of WORD_W and no greater than 1600.
- NUM_WORDS, OUT_BITS/WORD_W, derived constant; not to be overridden.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- state_in  in  1600  final Keccak state; bit 64*i+z is bit z of lane i.
- state_valid  in  1  state_in holds a final state this cycle.
- state_ready  out  1  block can capture; high only in IDLE.
- out_data  out  WORD_W  current digest word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the word this cycle.
- out_last  out  1  current word is the final word of the digest.
- busy  out  1  high in SEND.

Behaviour:
- Reset, synchronous and active-high on clk:
  - state goes to IDLE; word index goes to 0; digest buffer is cleared to 0.
  - out_valid=0, out_last=0, busy=0, out_data=0, state_ready=1 (from the first cycle after reset).
- Reset has priority over every other event, including one arriving mid-SEND. The partial digest is discarded with no further out_valid.
- FSM states: IDLE, SEND.
- IDLE:
  - state_ready=1, out_valid=0.
  - When state_valid=1: buf <= state_in[OUT_BITS-1:0], idx <= 0, go to SEND.
  - Capture latency is 1 cycle; out_valid first rises the cycle after capture.
- SEND:
  - out_valid=1, busy=1, state_ready=0.
  - out_data = buf[WORD_W*idx +: WORD_W], so word 0 is the lowest bits of lane 0 (Keccak little-endian digest order).
  - out_last = (idx == NUM_WORDS-1).
  - A transfer occurs when out_valid && out_ready. On a transfer with idx < NUM_WORDS-1, idx increments.
  - On a transfer with idx == NUM_WORDS-1: go to IDLE and set idx <= 0. out_valid drops the next cycle.
  - While out_ready=0, out_data, out_last and idx hold stable. There is no timeout.
- state_valid while in SEND is ignored, because state_ready=0. The upstream core must hold or retry.
- Throughput: NUM_WORDS transfer cycles plus 1 capture cycle per digest. With out_ready held high, back-to-back digests arrive every NUM_WORDS+1 cycles.
- out_data is muxed from registered buf and idx only; there is no combinational path from any input to any output.
- idx width is clog2(NUM_WORDS), minimum 1 bit.
- For NUM_WORDS=1, out_last is constant 1 in SEND.
- Elaboration must fail (assertion) if OUT_BITS % WORD_W != 0 or OUT_BITS > 1600.

Decomposition:
- Shared package keccak_pkg holds:
  - STATE_W=1600, LANE_W=64, LANE_CNT=25.
  - The FSM enum sq_state_t {SQ_IDLE, SQ_SEND}.
- No sub-module is required. The word-select mux is a single indexed part-select inside this block.

Test Plan:
- Basic, WORD_W=64, OUT_BITS=256: state_in lanes 0..3 = 64'h1, 64'h2, 64'h3, 64'h4; all other lanes 64'hFFFF_FFFF_FFFF_FFFF; pulse state_valid with out_ready=1.
  - Required: out_valid rises the next cycle; words 1, 2, 3, 4 on 4 consecutive cycles; out_last only on word 4; then state_ready=1.
- Backpressure: same stimulus, out_ready toggled 1,0,0,1,0,1,1.
  - Required: exactly 4 transfers carrying 1, 2, 3, 4 in order; out_data and out_last unchanged during stalled cycles.
- Ignored input: during SEND, present a new state with lane 0 = 64'hDEAD and pulse state_valid.
  - Required: current digest completes unchanged; 64'hDEAD is never output; state_ready=0 throughout SEND.
- Mid-operation reset: assert rst for 1 cycle after word 2 is transferred.
  - Required: next cycle out_valid=0, busy=0, state_ready=1, out_data=0. A fresh capture afterwards restarts at word 0.
- Parameter variant, WORD_W=32, OUT_BITS=224: lane 0 = 64'hBBBB_BBBB_AAAA_AAAA, lane 1 = 64'hDDDD_DDDD_CCCC_CCCC, lane 2 = 64'hFFFF_FFFF_EEEE_EEEE, lane 3 = 64'h9999_9999_8888_8888.
  - Required: 7 words AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD, EEEEEEEE, FFFFFFFF, 88888888, with out_last on the 7th.
- Back-to-back: second state_valid asserted the cycle after the last transfer.
  - Required: second digest captured then; its first word appears 1 cycle later; one idle cycle between the two digests.
